// File: rtl/ta_score_stream.sv
`default_nettype none
// ============================================================================
// Module      : ta_score_stream
// Description : Fetches a weight row and N token rows, mean-thresholds each
//               token, buffers the dot-product scores and streams them out.
// Revision    : 1.0 - initial release
// ============================================================================
module ta_score_stream #(
    parameter int EW     = 4,
    parameter int DIM    = 8,
    parameter int LEN_W  = 2,
    parameter int ADDR_W = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    input  logic [LEN_W-1:0]              i_length,
    input  logic                          i_mode,
    input  logic [ADDR_W-1:0]             i_base,
    output logic                          o_busy,
    output logic                          m_read,
    output logic [ADDR_W-1:0]             m_addr,
    input  logic [DIM*EW-1:0]             m_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [2*EW+$clog2(DIM)-1:0]   o_data,
    output logic                          o_last
);

    localparam int c_LDIM  = $clog2(DIM);
    localparam int c_SW    = 2 * EW + c_LDIM;
    localparam int c_MAX_N = 4 << ((1 << LEN_W) - 1);
    localparam int c_CW    = $clog2(c_MAX_N);
    localparam int c_AW    = c_SW + c_CW;
    localparam int c_SUMW  = EW + c_LDIM;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FETCH_W = 3'd1;
    localparam logic [2:0] c_FETCH_T = 3'd2;
    localparam logic [2:0] c_DRAIN   = 3'd3;
    localparam logic [2:0] c_OUT     = 3'd4;

    logic [2:0]          r_state;
    logic [c_CW-1:0]     r_cnt;
    logic [LEN_W-1:0]    r_len;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_base;
    logic [c_AW-1:0]     r_acc;
    logic [DIM*EW-1:0]   r_wword;
    logic                r_w_vld;
    logic                r_tok_vld;
    logic [c_CW-1:0]     r_tok_idx;
    logic [c_SW-1:0]     r_buf [c_MAX_N];

    logic [c_CW-1:0]     w_last_idx;
    logic [c_SUMW-1:0]   w_sum;
    logic [EW-1:0]       w_mean;
    logic [EW-1:0]       w_elem;
    logic [c_SW-1:0]     w_score;
    logic [c_SW-1:0]     w_sel;
    logic [c_AW-1:0]     w_smean;

    // N - 1 from the length code; N = MAX_N wraps to all ones in c_CW bits
    assign w_last_idx = c_CW'((c_CW + 1)'(4) << r_len) - c_CW'(1);

    always_comb begin
        w_sum   = '0;
        w_elem  = '0;
        w_score = '0;
        for (int j = 0; j < DIM; j++) begin
            w_sum = w_sum + c_SUMW'(m_data[(DIM-1-j)*EW +: EW]);
        end
        w_mean = w_sum[c_SUMW-1:c_LDIM];
        for (int j = 0; j < DIM; j++) begin
            w_elem = m_data[(DIM-1-j)*EW +: EW];
            if (w_elem >= w_mean) begin
                w_score = w_score + c_SW'(w_elem) * c_SW'(r_wword[(DIM-1-j)*EW +: EW]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_mode    <= 1'b0;
            r_base    <= '0;
            r_acc     <= '0;
            r_wword   <= '0;
            r_w_vld   <= 1'b0;
            r_tok_vld <= 1'b0;
            r_tok_idx <= '0;
        end else begin
            // Read data lands one cycle after the strobe, so track what is in flight
            r_w_vld   <= (r_state == c_FETCH_W);
            r_tok_vld <= (r_state == c_FETCH_T);
            r_tok_idx <= r_cnt;
            if (r_w_vld) begin
                r_wword <= m_data;
            end
            if (r_tok_vld) begin
                r_acc <= r_acc + c_AW'(w_score);
            end
            case (r_state)
                c_IDLE: begin
                    if (i_valid) begin
                        r_len   <= i_length;
                        r_mode  <= i_mode;
                        r_base  <= i_base;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_FETCH_W;
                    end
                end
                c_FETCH_W: begin
                    r_cnt   <= '0;
                    r_state <= c_FETCH_T;
                end
                c_FETCH_T: begin
                    if (r_cnt == w_last_idx) begin
                        r_cnt   <= '0;
                        r_state <= c_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_DRAIN: begin
                    r_cnt   <= '0;
                    r_state <= c_OUT;
                end
                c_OUT: begin
                    if (o_ready) begin
                        if (r_cnt == w_last_idx) begin
                            r_cnt   <= '0;
                            r_state <= c_IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_CW'(1);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_tok_vld) begin
            r_buf[r_tok_idx] <= w_score;
        end
    end

    assign w_sel   = r_buf[r_cnt];
    assign w_smean = r_acc >> (32'(r_len) + 32'd2);

    assign o_busy  = (r_state != c_IDLE);
    assign m_read  = (r_state == c_FETCH_W) || (r_state == c_FETCH_T);
    assign m_addr  = (r_state == c_FETCH_W) ? r_base :
                     (r_state == c_FETCH_T) ? r_base + ADDR_W'(1) + ADDR_W'(r_cnt) :
                     '0;
    assign o_valid = (r_state == c_OUT);
    assign o_last  = o_valid && (r_cnt == w_last_idx);
    assign o_data  = !o_valid                            ? '0 :
                     (r_mode && (c_AW'(w_sel) < w_smean)) ? '0 :
                     w_sel;

endmodule
`default_nettype wire

// File: tb/tb_ta_score_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_ta_score_stream
// Description : Scoreboard bench for ta_score_stream with a one-cycle memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ta_score_stream;

    localparam int EW = 4, DIM = 8, LEN_W = 2, ADDR_W = 6, SW = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid;
    logic [LEN_W-1:0]  i_length;
    logic              i_mode;
    logic [ADDR_W-1:0] i_base;
    logic              o_busy;
    logic              m_read;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_data = '0;
    logic              o_valid;
    logic              o_ready;
    logic [SW-1:0]     o_data;
    logic              o_last;

    logic [31:0] mem [64];
    logic [11:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) m_data <= m_read ? mem[m_addr] : 32'h0;

    ta_score_stream #(.EW(EW), .DIM(DIM), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_length(i_length),
        .i_mode(i_mode), .i_base(i_base), .o_busy(o_busy), .m_read(m_read),
        .m_addr(m_addr), .m_data(m_data), .o_valid(o_valid), .o_ready(o_ready),
        .o_data(o_data), .o_last(o_last)
    );

    function automatic int model_score(logic [31:0] t, logic [31:0] w);
        int sum = 0;
        int s = 0;
        int mean;
        for (int j = 0; j < 8; j++) sum += int'(t[31-4*j -: 4]);
        mean = sum / 8;
        for (int j = 0; j < 8; j++)
            if (int'(t[31-4*j -: 4]) >= mean) s += int'(t[31-4*j -: 4]) * int'(w[31-4*j -: 4]);
        return s;
    endfunction

    task automatic push_model(int base, int len, int mode);
        int n = 4 << len;
        int acc = 0;
        int v;
        int sc [32];
        for (int i = 0; i < n; i++) begin
            sc[i] = model_score(mem[(base + 1 + i) % 64], mem[base]);
            acc += sc[i];
        end
        for (int i = 0; i < n; i++) begin
            v = (mode == 1 && sc[i] < acc / n) ? 0 : sc[i];
            exp_q.push_back({(i == n - 1), 11'(v)});
        end
    endtask

    task automatic push_const(int a, int b, int c, int d);
        exp_q.push_back({1'b0, 11'(a)});
        exp_q.push_back({1'b0, 11'(b)});
        exp_q.push_back({1'b0, 11'(c)});
        exp_q.push_back({1'b1, 11'(d)});
    endtask

    task automatic load_basic(int base);
        mem[base]     = 32'h11111111;
        mem[base + 1] = 32'h12345678;
        mem[base + 2] = 32'hFFFFFFFF;
        mem[base + 3] = 32'h00000000;
        mem[base + 4] = 32'h0000000F;
    endtask

    task automatic issue(int len, int mode, int base);
        i_length = LEN_W'(len);
        i_mode   = mode[0];
        i_base   = ADDR_W'(base);
        i_valid  = 1'b1;
        @(posedge clk); #1;
        i_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_valid = 1'b0; i_length = '0; i_mode = 1'b0; i_base = '0; o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %0d expected 0", o_busy); end
        checks++; if (m_read !== 1'b0)  begin failures++; $display("FAIL reset_read: got %0d expected 0", m_read); end
        checks++; if (m_addr !== 6'd0)  begin failures++; $display("FAIL reset_addr: got %0d expected 0", m_addr); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0d expected 0", o_valid); end
        checks++; if (o_data !== 11'd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", o_data); end
        checks++; if (o_last !== 1'b0)  begin failures++; $display("FAIL reset_last: got %0d expected 0", o_last); end
        @(posedge clk); #1;
    endtask

    task automatic test_mode0;
        logic [5:0] ea;
        load_basic(0);
        push_const(30, 120, 0, 15);
        issue(0, 0, 0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            o_ready = 1'b1;
            @(negedge clk);
            ea = (cyc <= 5) ? 6'(cyc - 1) : 6'd0;
            checks++; if (m_read !== (cyc <= 5)) begin failures++; $display("FAIL mode0_read c%0d: got %0d expected %0d", cyc, m_read, cyc <= 5); end
            checks++; if (m_addr !== ea) begin failures++; $display("FAIL mode0_addr c%0d: got %0d expected %0d", cyc, m_addr, ea); end
            checks++; if (o_valid !== (cyc >= 7 && cyc <= 10)) begin failures++; $display("FAIL mode0_valid c%0d: got %0d", cyc, o_valid); end
            if (o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL mode0_extra: got %0d expected none", o_data); end
                else if ({o_last, o_data} !== exp_q[0]) begin failures++; $display("FAIL mode0_data: got %0d/%0d expected %0d/%0d", o_data, o_last, exp_q[0][10:0], exp_q[0][11]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (cyc == 11) begin checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL mode0_busy_end: got %0d expected 0", o_busy); end end
            @(posedge clk); #1;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mode0_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_mode1;
        push_const(0, 120, 0, 0);
        issue(0, 1, 0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            o_ready = 1'b1;
            @(negedge clk);
            checks++; if (o_valid !== (cyc >= 7 && cyc <= 10)) begin failures++; $display("FAIL mode1_valid c%0d: got %0d", cyc, o_valid); end
            if (o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL mode1_extra: got %0d expected none", o_data); end
                else if ({o_last, o_data} !== exp_q[0]) begin failures++; $display("FAIL mode1_data: got %0d/%0d expected %0d/%0d", o_data, o_last, exp_q[0][10:0], exp_q[0][11]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mode1_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_backpressure;
        int held = 0;
        push_const(30, 120, 0, 15);
        issue(0, 0, 0);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            o_ready = !(cyc >= 8 && cyc <= 10);
            @(negedge clk);
            if (o_valid) begin
                checks++;
                if (o_data == 11'd120) held++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra: got %0d expected none", o_data); end
                else if ({o_last, o_data} !== exp_q[0]) begin failures++; $display("FAIL bp_data c%0d: got %0d/%0d expected %0d/%0d", cyc, o_data, o_last, exp_q[0][10:0], exp_q[0][11]); end
                if (o_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (cyc == 14) begin checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL bp_busy_end: got %0d expected 0", o_busy); end end
            @(posedge clk); #1;
        end
        o_ready = 1'b1;
        checks++; if (held != 4) begin failures++; $display("FAIL bp_hold: got %0d cycles expected 4", held); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_busy_reject;
        int reads = 0;
        push_const(30, 120, 0, 15);
        issue(0, 0, 0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            o_ready  = 1'b1;
            i_valid  = (cyc == 3 || cyc == 10);
            i_length = 2'd1;
            i_base   = 6'd20;
            @(negedge clk);
            if (m_read) begin
                reads++;
                checks++; if (m_addr !== 6'(cyc - 1)) begin failures++; $display("FAIL busy_addr c%0d: got %0d expected %0d", cyc, m_addr, cyc - 1); end
            end
            if (o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL busy_extra: got %0d expected none", o_data); end
                else if ({o_last, o_data} !== exp_q[0]) begin failures++; $display("FAIL busy_data: got %0d/%0d expected %0d/%0d", o_data, o_last, exp_q[0][10:0], exp_q[0][11]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (cyc == 12) begin checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL busy_ignored: got %0d expected 0", o_busy); end end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        checks++; if (reads != 5) begin failures++; $display("FAIL busy_reads: got %0d expected 5", reads); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL busy_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        mem[30] = 32'h21436587;
        for (int i = 31; i <= 34; i++) mem[i] = $urandom;
        push_model(30, 0, 0);
        issue(0, 0, 30);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            o_ready = 1'b1;
            @(negedge clk);
            if (cyc == 1) begin
                checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL third_busy: got %0d expected 1", o_busy); end
                checks++; if (m_addr !== 6'd30) begin failures++; $display("FAIL third_addr: got %0d expected 30", m_addr); end
            end
            if (o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL third_extra: got %0d expected none", o_data); end
                else if ({o_last, o_data} !== exp_q[0]) begin failures++; $display("FAIL third_data: got %0d/%0d expected %0d/%0d", o_data, o_last, exp_q[0][10:0], exp_q[0][11]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL third_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_wrap;
        int outs = 0;
        logic [5:0] ea;
        mem[62] = $urandom;
        mem[63] = $urandom;
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        push_model(62, 1, 1);
        issue(1, 1, 62);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            o_ready = 1'b1;
            @(negedge clk);
            ea = (cyc <= 9) ? 6'((62 + cyc - 1) % 64) : 6'd0;
            checks++; if (m_read !== (cyc <= 9)) begin failures++; $display("FAIL wrap_read c%0d: got %0d expected %0d", cyc, m_read, cyc <= 9); end
            checks++; if (m_addr !== ea) begin failures++; $display("FAIL wrap_addr c%0d: got %0d expected %0d", cyc, m_addr, ea); end
            if (o_valid) begin
                outs++;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_extra: got %0d expected none", o_data); end
                else if ({o_last, o_data} !== exp_q[0]) begin failures++; $display("FAIL wrap_data: got %0d/%0d expected %0d/%0d", o_data, o_last, exp_q[0][10:0], exp_q[0][11]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (cyc == 19) begin checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL wrap_busy_end: got %0d expected 0", o_busy); end end
            @(posedge clk); #1;
        end
        checks++; if (outs != 8) begin failures++; $display("FAIL wrap_count: got %0d expected 8", outs); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid;
        load_basic(0);
        issue(0, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (m_read !== 1'b0)  begin failures++; $display("FAIL rmid_read: got %0d expected 0", m_read); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %0d expected 0", o_valid); end
        checks++; if (o_busy !== 1'b0)  begin failures++; $display("FAIL rmid_busy: got %0d expected 0", o_busy); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale: got busy=%0d valid=%0d expected 0", o_busy, o_valid); end
        push_const(30, 120, 0, 15);
        issue(0, 0, 0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            o_ready = 1'b1;
            @(negedge clk);
            checks++; if (o_valid !== (cyc >= 7 && cyc <= 10)) begin failures++; $display("FAIL rmid_valid c%0d: got %0d", cyc, o_valid); end
            if (o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL rmid_extra: got %0d expected none", o_data); end
                else if ({o_last, o_data} !== exp_q[0]) begin failures++; $display("FAIL rmid_data: got %0d/%0d expected %0d/%0d", o_data, o_last, exp_q[0][10:0], exp_q[0][11]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_backpressure();
        test_busy_reject();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ta_score_stream.md
# ta_score_stream

Parametrised successor to the team's token-attention datapath for the memory-fed attention flow. The block takes a start command with a length code, a base address and a mode. It fetches one weight row and N token rows from the virtual memory and mean-thresholds each token row. It computes each row's dot product with the weight row, buffers the N scores, then streams them out under a valid/ready handshake. In mode 1 the scores are also thresholded against their own mean.

## Interface
Parameters:
- EW, 4, element width in bits (unsigned)
- DIM, 8, elements per memory word; power of two ≥ 2
- LEN_W, 2, length-code width; N = 4 << i_length, MAX_N = 4 << (2^LEN_W − 1)
- ADDR_W, 6, memory address width
- Derived: SW = 2·EW + log2(DIM) (score width, 11 by default); AW = SW + log2(MAX_N) (accumulator width)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  start pulse; sampled only when o_busy = 0
- i_length  in  LEN_W  length code, captured with i_valid
- i_mode  in  1  0 = raw scores, 1 = score mean-thresholding; captured with i_valid
- i_base  in  ADDR_W  base address, captured with i_valid
- o_busy  out  1  high from the cycle after accept until the cycle after the final handshake
- m_read  out  1  memory read strobe
- m_addr  out  ADDR_W  read address; 0 when m_read = 0
- m_data  in  DIM·EW  read data, valid exactly one cycle after m_read; element 0 in the MSBs
- o_valid  out  1  score available
- o_ready  in  1  downstream accept
- o_data  out  SW  score; 0 when o_valid = 0
- o_last  out  1  high with the score of token N−1

## Operation
- States: IDLE, FETCH_W, FETCH_T, DRAIN, OUT. Reset drives IDLE; all outputs, the counter and the accumulator reset to 0. The score buffer (MAX_N × SW) has no reset.
- IDLE → FETCH_W when i_valid is sampled. i_valid is ignored in every other state, including the cycle of the final handshake.
- FETCH_W (1 cycle): m_read = 1, m_addr = base.
- FETCH_T (N cycles, k = 0..N−1): m_read = 1, m_addr = (base + 1 + k) mod 2^ADDR_W; wrap-around is legal.
- DRAIN (1 cycle): no read; the last token's data is processed.
- Weight word: registered as w[0..DIM−1] at the end of the cycle it arrives.
- Token word (combinational in its arrival cycle, registered at end of cycle):
  - sum = Σ elements; mean = floor(sum / DIM) via right shift.
  - t'[j] = t[j] if t[j] ≥ mean, else 0.
  - score = Σ t'[j]·w[j], unsigned SW bits, no overflow possible.
  - The score is written to buf[k] and added to the AW-bit accumulator.
- OUT: index n starts at 0; o_valid = 1, o_data = f(buf[n]), o_last = (n == N−1).
  - mode 0: f(s) = s.
  - mode 1: f(s) = s if s ≥ smean else 0, where smean = floor(acc / N).
  - n advances only on o_valid & o_ready; the handshake at n = N−1 → IDLE.
- Backpressure: while o_valid & !o_ready, o_data and o_last hold stable. No cap on stall length.
- Reset mid-operation: immediate return to IDLE, outputs 0, no stale output after reset release. The next command starts clean, with the accumulator cleared on accept.

## Timing
- Cycle 0: edge sampling i_valid. Cycle 1: FETCH_W, o_busy = 1.
- Cycles 2..N+1: FETCH_T. Weight data arrives in cycle 2; token k data arrives in cycle 3+k.
- Cycle N+2: DRAIN. Cycle N+3: first o_valid.
- With o_ready held 1: one score per cycle, last handshake in cycle 2N+2; IDLE and o_busy = 0 in cycle 2N+3.
- The earliest next accepted i_valid is sampled at the end of cycle 2N+3.
- m_read is high for exactly N+1 consecutive cycles per command.

## Test plan
- Mode 0, code 0 (N = 4), base 0, o_ready = 1. Memory: w = 0x11111111; tokens 0x12345678, 0xFFFFFFFF, 0x00000000, 0x0000000F. Required: o_data 30, 120, 0, 15 in cycles 7..10; o_last only with 15; m_addr 0..4 in cycles 1..5.
- Same data with mode 1: smean = floor(165/4) = 41. Required: outputs 0, 120, 0, 0.
- Backpressure: same data, o_ready low for 3 cycles at the second score. Required: o_data stays 120 for 4 cycles; the sequence is unchanged and no score is lost or duplicated.
- Busy rejection: a second i_valid with different length/base during FETCH_T and again on the final handshake cycle. Required: both ignored, no extra reads; a third i_valid after o_busy falls is accepted.
- Wrap and length: base 62, code 1 (N = 8). Required: m_addr 62, 63, 0..7; 8 scores out; o_last on the 8th; o_busy low in cycle 19.
- Reset mid-operation: assert rst_n low during FETCH_T. Required: m_read, o_valid, o_busy = 0 immediately. A fresh command after release yields the correct first-test scores.
